load_unit: RTL and testbench
============================

# load_unit

Memory-read side of the datapath's load/store path: the counterpart to the store merge logic. It accepts a load request (lw/lh/lhu/lb/lbu) from the control unit and issues a word-aligned read to data memory over a req/ack handshake. It extracts and sign- or zero-extends the addressed byte or halfword and returns the result for register write-back with a one-cycle `done` pulse. A bus timeout and an optional misalignment check report errors to the exception logic.

## Interface
- `TIMEOUT`, default 15: cycles to wait for `mem_ack` before a bus error; 0 waits forever.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: load request; accepted only in IDLE or DONE.
- `Address` in 32: byte address, captured at accept.
- `mode` in 3: captured at accept.
  - `mode[1:0]`: 00 word, 01 half, 10 byte; 11 is treated as word.
  - `mode[2]`: 1 zero-extend, 0 sign-extend; ignored for word.
- `mem_req` out 1: read request, held until ack or timeout.
- `mem_addr` out 32: `{Address[31:2], 2'b00}` of the captured address.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory word, little-endian (byte 0 = bits 7:0).
- `busy` out 1: high in REQ and ERRWAIT.
- `done` out 1: one-cycle completion pulse.
- `RegOut` out 32: extended load result; valid from `done` until the next `done`.
- `bus_err` out 1: with `done`, marks a timeout; `RegOut` is unchanged.
- `addr_err` out 1: with `done`, marks a misaligned access (see Configuration).

## Operation
- States and transitions:
  - IDLE: `start` → REQ, or → ERRWAIT if misaligned.
  - REQ: `mem_ack` → DONE; `TIMEOUT` reached → DONE with bus error.
  - ERRWAIT → DONE.
  - DONE: `start` → REQ or ERRWAIT; otherwise → IDLE.
- Accept: latch `Address`, `mode`; clear the timeout counter.
- REQ: `mem_req`=1 and `mem_addr` stable.
  - Counter increments each cycle without ack.
  - If `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1 with no ack: drop `mem_req`, go to DONE with `bus_err`=1.
- Capture on `mem_ack`, using offset `o` = `Address[1:0]`:
  - Word: `RegOut` = `mem_rdata`.
  - Half: `h` = `o[1]` ? `mem_rdata[31:16]` : `mem_rdata[15:0]`, extended to 32 bits.
  - Byte: `b` = `mem_rdata[8*o+7 : 8*o]`, extended to 32 bits.
- Sign extension replicates the MSB of the extracted field; zero extension pads with 0.
- `RegOut` updates only on a successful ack; error completions leave it unchanged.
- `mem_ack` outside REQ is ignored.
- `start` while `busy` is ignored; it is not queued.
- `start` in DONE is accepted, giving back-to-back loads with no idle cycle.

## Timing
- Reset values: state IDLE; `mem_req`, `busy`, `done`, `bus_err`, `addr_err` = 0; `RegOut`, `mem_addr` = 0; counter = 0.
- Reset mid-operation drops `mem_req` asynchronously. A late `mem_ack` after reset is ignored.
- Latency: `start` sampled at edge N → `mem_req` high in cycle N+1.
- Ack in cycle N+1+k → `done` in cycle N+2+k.
- Minimum start-to-done latency is 2 cycles. Back-to-back throughput is one load per 2 cycles when acked immediately.
- Timeout: `done`/`bus_err` occur `TIMEOUT`+1 cycles after accept.
- `bus_err` and `addr_err` are valid only while `done`=1; otherwise 0.

## Configuration
- `LOAD_UNIT_MISALIGN_EXC_EN` defined:
  - A word access with `o`≠0, or a half access with `o[0]`=1, never asserts `mem_req`.
  - It goes IDLE/DONE → ERRWAIT → DONE with `addr_err`=1, so `done` comes 2 cycles after accept.
  - `RegOut` is unchanged.
- Not defined:
  - No check is made; `addr_err` is tied 0.
  - Word ignores `o`; half uses only `o[1]`; all accesses go to memory.

## Test plan
- Every 2-cycle load is a `start` pulse with memory acking in the first REQ cycle.
- Sign vs zero byte: `mem_rdata`=0x80FF7F01, `Address`=0x100+3.
  - lb gives `RegOut`=0xFFFFFF80; lbu gives 0x00000080.
  - Both have `mem_addr`=0x100 and `done` 2 cycles after `start`.
- Halves: `mem_rdata`=0x9ABC1234.
  - lh @0x202 gives 0xFFFF9ABC; lhu @0x202 gives 0x00009ABC; lh @0x200 gives 0x00001234.
- Wait states: ack delayed 5 cycles.
  - `mem_req` stays high 6 cycles with `mem_addr` stable.
  - `done` 7 cycles after `start`; `start` pulses while `busy` are ignored, producing no extra `done`.
- Timeout: `TIMEOUT`=4, never ack.
  - `mem_req` is high for 4 cycles; `done`=`bus_err`=1 in cycle 5; `RegOut` keeps its prior value.
  - A new lw then completes normally.
- Misaligned lw @0x103:
  - With `LOAD_UNIT_MISALIGN_EXC_EN`: no `mem_req`, `done`=`addr_err`=1 two cycles after `start`.
  - Without it: `mem_addr`=0x100 and `RegOut`=`mem_rdata`.
- Reset during REQ: `reset_n` low mid-wait gives `mem_req`=0 immediately and all outputs 0. A subsequent `mem_ack` produces no `done`.

Source files
------------

// File: rtl/load_unit_if.sv
// Memory read port between the load unit and data memory.
// Latency: none, plain wires.
// Backpressure: req is held by the master until ack arrives; ack and rdata are valid in the same cycle.
//
// Signals:
//   mem_req   - read request, high while the master waits for data
//   mem_addr  - word-aligned byte address of the read
//   mem_ack   - read complete, mem_rdata valid this cycle
//   mem_rdata - little-endian memory word (byte 0 = bits 7:0)
interface load_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/load_unit.sv
// Load unit: issues a word read for lw/lh/lhu/lb/lbu, extracts and extends the addressed field.
// Latency: start to done is 2 cycles with an immediate ack, plus one cycle per memory wait state.
// Backpressure: start is accepted only in IDLE/DONE; start while busy is dropped, not queued.
//
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   start             - load request (Address, mode captured on accept)
//   Address[31:0]     - byte address
//   mode[2:0]         - [1:0] 00 word, 01 half, 10 byte, 11 word; [2] 1 = zero-extend
//   mem               - memory read port (load_unit_if.master)
//   busy              - high while waiting on memory or reporting an address error
//   done              - one-cycle completion pulse
//   RegOut[31:0]      - extended load result, updated only on a successful ack
//   bus_err, addr_err - error qualifiers, valid only with done
//
// Build option: define LOAD_UNIT_MISALIGN_EXC_EN to trap misaligned word/half accesses
// (no memory request, done with addr_err). Without it, low address bits are ignored
// for words and bit 0 is ignored for halves.
module load_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] Address,
    input  logic [2:0]  mode,
    load_unit_if.master mem,
    output logic        busy,
    output logic        done,
    output logic [31:0] RegOut,
    output logic        bus_err,
    output logic        addr_err
);

    // Counter only ever needs to reach TIMEOUT-1; with TIMEOUT=0 it simply wraps.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ERRWAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     off_q;       // byte offset within the word
    logic [2:0]     mode_q;
    logic [31:0]    addr_q;      // drives mem_addr, already word aligned
    logic [CW-1:0]  cnt;
    logic           bus_err_q;
    logic           accept;
    logic           misalign;
    logic           timeout_hit;
    logic [31:0]    load_val;

    assign accept      = start && ((state == IDLE) || (state == DONE));
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

`ifdef LOAD_UNIT_MISALIGN_EXC_EN
    logic addr_err_q;

    // Bytes are always aligned; halves need bit 0 clear; words (including mode 11) need both clear.
    always_comb begin
        misalign = 1'b0;
        case (mode[1:0])
            2'b01:   misalign = Address[0];
            2'b10:   misalign = 1'b0;
            default: misalign = (Address[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err_q <= 1'b0;
        end else if (accept) begin
            addr_err_q <= misalign;
        end
    end

    assign addr_err = done && addr_err_q;
`else
    assign misalign = 1'b0;
    assign addr_err = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = misalign ? ERRWAIT : REQ;
                end
            end
            REQ: begin
                if (mem.mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            ERRWAIT: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = misalign ? ERRWAIT : REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Field extraction from the returned word
    // ---------------------------------------------------------------
    always_comb begin
        logic [15:0] half;
        logic [7:0]  byt;

        load_val = mem.mem_rdata;
        half     = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        byt      = mem.mem_rdata[7:0];
        case (off_q)
            2'd0:    byt = mem.mem_rdata[7:0];
            2'd1:    byt = mem.mem_rdata[15:8];
            2'd2:    byt = mem.mem_rdata[23:16];
            default: byt = mem.mem_rdata[31:24];
        endcase

        case (mode_q[1:0])
            2'b01:   load_val = mode_q[2] ? {16'h0000, half} : {{16{half[15]}}, half};
            2'b10:   load_val = mode_q[2] ? {24'h000000, byt} : {{24{byt[7]}}, byt};
            default: load_val = mem.mem_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            off_q     <= 2'b00;
            mode_q    <= 3'b000;
            addr_q    <= 32'h0;
            cnt       <= '0;
            bus_err_q <= 1'b0;
            RegOut    <= 32'h0;
        end else if (accept) begin
            off_q     <= Address[1:0];
            mode_q    <= mode;
            addr_q    <= {Address[31:2], 2'b00};
            cnt       <= '0;
            bus_err_q <= 1'b0;
        end else if (state == REQ) begin
            if (mem.mem_ack) begin
                RegOut <= load_val;
            end else if (timeout_hit) begin
                // Error completion leaves RegOut holding the previous result.
                bus_err_q <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // State-decoded outputs; the async reset of state drops mem_req immediately.
    assign mem.mem_req  = (state == REQ);
    assign mem.mem_addr = addr_q;
    assign busy         = (state == REQ) || (state == ERRWAIT);
    assign done         = (state == DONE);
    assign bus_err      = done && bus_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: extension modes, wait states, timeout, misalignment, reset.
// A second instance with TIMEOUT=4 covers the bus-error path.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        start_to;
    logic [31:0] Address;
    logic [2:0]  mode;

    logic        busy, done, bus_err, addr_err;
    logic [31:0] RegOut;
    logic        busy_to, done_to, bus_err_to, addr_err_to;
    logic [31:0] RegOut_to;

    int errors = 0;
    int checks = 0;

    // run_load observations
    int          req_cyc;
    int          done_lat;
    logic [31:0] addr_seen;
    logic        addr_stable;

    localparam logic [2:0] LW  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LB  = 3'b010;
    localparam logic [2:0] LBU = 3'b110;
    localparam logic [2:0] LW3 = 3'b011;

    load_unit_if mif ();
    load_unit_if mif_to ();

    load_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .Address  (Address),
        .mode     (mode),
        .mem      (mif.master),
        .busy     (busy),
        .done     (done),
        .RegOut   (RegOut),
        .bus_err  (bus_err),
        .addr_err (addr_err)
    );

    load_unit #(.TIMEOUT(4)) dut_to (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start_to),
        .Address  (Address),
        .mode     (mode),
        .mem      (mif_to.master),
        .busy     (busy_to),
        .done     (done_to),
        .RegOut   (RegOut_to),
        .bus_err  (bus_err_to),
        .addr_err (addr_err_to)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one load on dut; memory acks after 'waits' request cycles.
    // Returns with the bench positioned in the cycle where done is expected.
    task automatic run_load(input logic [31:0] a, input logic [2:0] m,
                            input logic [31:0] rd, input int waits);
        start   = 1'b1;
        Address = a;
        mode    = m;
        tick();
        start       = 1'b0;
        done_lat    = 1;
        req_cyc     = 0;
        addr_stable = 1'b1;
        addr_seen   = mif.mem_addr;
        for (int c = 0; c < 40; c++) begin
            if (done) break;
            if (mif.mem_req) begin
                req_cyc++;
                if (mif.mem_addr !== addr_seen) addr_stable = 1'b0;
                if (req_cyc == waits + 1) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = rd;
                end
            end
            tick();
            done_lat++;
            mif.mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        start            = 1'b0;
        start_to         = 1'b0;
        Address          = 32'h0;
        mode             = 3'b000;
        mif.mem_ack      = 1'b0;
        mif.mem_rdata    = 32'h0;
        mif_to.mem_ack   = 1'b0;
        mif_to.mem_rdata = 32'h0;
        #2;
        checks++;
        if ({mif.mem_req, busy, done, bus_err, addr_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got req/busy/done/berr/aerr=%b want 00000",
                     {mif.mem_req, busy, done, bus_err, addr_err});
        end
        checks++;
        if ({RegOut, mif.mem_addr} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got RegOut=%h mem_addr=%h want 0/0", RegOut, mif.mem_addr);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_bytes();
        run_load(32'h103, LB, 32'h80FF7F01, 0);
        checks++;
        if (RegOut !== 32'hFFFFFF80 || done_lat != 2 || addr_seen !== 32'h100) begin
            errors++;
            $display("FAIL lb_3: got RegOut=%h lat=%0d addr=%h want FFFFFF80 2 00000100",
                     RegOut, done_lat, addr_seen);
        end
        run_load(32'h103, LBU, 32'h80FF7F01, 0);
        checks++;
        if (RegOut !== 32'h00000080 || done_lat != 2 || addr_seen !== 32'h100) begin
            errors++;
            $display("FAIL lbu_3: got RegOut=%h lat=%0d addr=%h want 00000080 2 00000100",
                     RegOut, done_lat, addr_seen);
        end
        run_load(32'h101, LB, 32'h80FF7F01, 0);
        checks++;
        if (RegOut !== 32'h0000007F) begin
            errors++;
            $display("FAIL lb_1: got %h want 0000007F", RegOut);
        end
        run_load(32'h102, LB, 32'h80FF7F01, 0);
        checks++;
        if (RegOut !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL lb_2: got %h want FFFFFFFF", RegOut);
        end
        run_load(32'h100, LBU, 32'h80FF7F01, 0);
        checks++;
        if (RegOut !== 32'h00000001) begin
            errors++;
            $display("FAIL lbu_0: got %h want 00000001", RegOut);
        end
        tick();
    endtask

    task automatic test_halves();
        run_load(32'h202, LH, 32'h9ABC1234, 0);
        checks++;
        if (RegOut !== 32'hFFFF9ABC || addr_seen !== 32'h200) begin
            errors++;
            $display("FAIL lh_hi: got RegOut=%h addr=%h want FFFF9ABC 00000200", RegOut, addr_seen);
        end
        run_load(32'h202, LHU, 32'h9ABC1234, 0);
        checks++;
        if (RegOut !== 32'h00009ABC) begin
            errors++;
            $display("FAIL lhu_hi: got %h want 00009ABC", RegOut);
        end
        run_load(32'h200, LH, 32'h9ABC1234, 0);
        checks++;
        if (RegOut !== 32'h00001234) begin
            errors++;
            $display("FAIL lh_lo: got %h want 00001234", RegOut);
        end
        run_load(32'h204, LW3, 32'hDEADBEEF, 0);
        checks++;
        if (RegOut !== 32'hDEADBEEF || bus_err !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL lw_mode3: got RegOut=%h berr=%b aerr=%b want DEADBEEF 0 0",
                     RegOut, bus_err, addr_err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_wait_states();
        int reqc;
        int extra;
        logic stable;
        reqc   = 0;
        extra  = 0;
        stable = 1'b1;
        start   = 1'b1;
        Address = 32'h300;
        mode    = LW;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (mif.mem_req) reqc++;
            if (mif.mem_addr !== 32'h300) stable = 1'b0;
            if (c == 2) begin
                start   = 1'b1;   // must be dropped while busy
                Address = 32'h400;
            end else begin
                start   = 1'b0;
            end
            if (c == 5) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = 32'h11223344;
            end
            tick();
        end
        start       = 1'b0;
        mif.mem_ack = 1'b0;
        checks++;
        if (reqc != 6 || stable !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: got req_cycles=%0d stable=%b want 6 1", reqc, stable);
        end
        checks++;
        if (done !== 1'b1 || RegOut !== 32'h11223344) begin
            errors++;
            $display("FAIL wait_done: got done=%b RegOut=%h want 1 11223344", done, RegOut);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done || mif.mem_req) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_start_dropped: got %0d extra done/req cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        run_load(32'h500, LW, 32'hA5A5A5A5, 0);
        lat1 = done_lat;
        // second start is issued while done is high
        run_load(32'h504, LBU, 32'h000000C3, 0);
        checks++;
        if (lat1 != 2 || done_lat != 2 || RegOut !== 32'h000000C3) begin
            errors++;
            $display("FAIL back_to_back: got lat=%0d/%0d RegOut=%h want 2/2 000000C3",
                     lat1, done_lat, RegOut);
        end
        tick();
    endtask

    task automatic test_timeout();
        int reqc;
        int lat;
        start_to = 1'b1;
        Address  = 32'h10;
        mode     = LW;
        tick();
        start_to         = 1'b0;
        mif_to.mem_ack   = 1'b1;
        mif_to.mem_rdata = 32'hCAFEF00D;
        tick();
        mif_to.mem_ack = 1'b0;
        checks++;
        if (done_to !== 1'b1 || RegOut_to !== 32'hCAFEF00D || bus_err_to !== 1'b0) begin
            errors++;
            $display("FAIL to_prime: got done=%b RegOut=%h berr=%b want 1 CAFEF00D 0",
                     done_to, RegOut_to, bus_err_to);
        end
        tick();
        start_to = 1'b1;
        Address  = 32'h20;
        tick();
        start_to = 1'b0;
        reqc     = 0;
        lat      = 1;
        for (int c = 0; c < 20; c++) begin
            if (done_to) break;
            if (mif_to.mem_req) reqc++;
            tick();
            lat++;
        end
        checks++;
        if (reqc != 4 || lat != 5) begin
            errors++;
            $display("FAIL to_timing: got req_cycles=%0d done_after=%0d want 4 5", reqc, lat);
        end
        checks++;
        if (bus_err_to !== 1'b1 || RegOut_to !== 32'hCAFEF00D || mif_to.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL to_err: got berr=%b RegOut=%h req=%b want 1 CAFEF00D 0",
                     bus_err_to, RegOut_to, mif_to.mem_req);
        end
        tick();
        checks++;
        if (bus_err_to !== 1'b0 || done_to !== 1'b0) begin
            errors++;
            $display("FAIL to_err_clear: got berr=%b done=%b want 0 0", bus_err_to, done_to);
        end
        start_to = 1'b1;
        Address  = 32'h24;
        tick();
        start_to         = 1'b0;
        mif_to.mem_ack   = 1'b1;
        mif_to.mem_rdata = 32'h0BADBEEF;
        tick();
        mif_to.mem_ack = 1'b0;
        checks++;
        if (done_to !== 1'b1 || bus_err_to !== 1'b0 || RegOut_to !== 32'h0BADBEEF) begin
            errors++;
            $display("FAIL to_recover: got done=%b berr=%b RegOut=%h want 1 0 0BADBEEF",
                     done_to, bus_err_to, RegOut_to);
        end
        tick();
    endtask

    task automatic test_misaligned();
        run_load(32'h600, LW, 32'h55667788, 0);
        tick();
        run_load(32'h103, LW, 32'h12345678, 0);
`ifdef LOAD_UNIT_MISALIGN_EXC_EN
        checks++;
        if (req_cyc != 0 || done_lat != 2 || addr_err !== 1'b1 || RegOut !== 32'h55667788) begin
            errors++;
            $display("FAIL misalign_lw: got req=%0d lat=%0d aerr=%b RegOut=%h want 0 2 1 55667788",
                     req_cyc, done_lat, addr_err, RegOut);
        end
`else
        checks++;
        if (addr_seen !== 32'h100 || RegOut !== 32'h12345678 || addr_err !== 1'b0 || done_lat != 2) begin
            errors++;
            $display("FAIL misalign_lw: got addr=%h RegOut=%h aerr=%b lat=%0d want 00000100 12345678 0 2",
                     addr_seen, RegOut, addr_err, done_lat);
        end
`endif
        tick();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL addr_err_clear: got %b want 0", addr_err);
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        start   = 1'b1;
        Address = 32'h700;
        mode    = LW;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mif.mem_req, busy, done, bus_err, addr_err} !== 5'b0 ||
            RegOut !== 32'h0 || mif.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got req/busy/done/berr/aerr=%b RegOut=%h addr=%h want 00000 0 0",
                     {mif.mem_req, busy, done, bus_err, addr_err}, RegOut, mif.mem_addr);
        end
        #3;
        reset_n       = 1'b1;
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hFFFF0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done || mif.mem_req) spurious++;
        end
        mif.mem_ack = 1'b0;
        checks++;
        if (spurious != 0 || RegOut !== 32'h0) begin
            errors++;
            $display("FAIL late_ack: got spurious=%0d RegOut=%h want 0 00000000", spurious, RegOut);
        end
    endtask

    initial begin
        test_reset();
        test_bytes();
        test_halves();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
